// File: rtl/crc_req_arbiter.sv
// Frame-level round-robin arbiter that time-shares one byte-wide CRC engine
// between NUM_REQ requesters and returns each frame's CRC tagged with its owner.
module crc_req_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 8,
    parameter int CRC_WIDTH  = 16,
    parameter int ENG_LAT    = 1,
    parameter int ID_W       = 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_vld,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_rdy,
    output logic                          eng_init,
    output logic                          eng_vld,
    output logic [DATA_WIDTH-1:0]         eng_din,
    input  logic [CRC_WIDTH-1:0]          eng_crc,
    output logic                          res_vld,
    input  logic                          res_rdy,
    output logic [ID_W-1:0]               res_id,
    output logic [CRC_WIDTH-1:0]          res_crc,
    output logic                          busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_INIT   = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_RESULT = 3'd4;

    localparam logic [ID_W:0]   L_NUM  = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] L_LAST = ID_W'(NUM_REQ - 1);
    localparam logic [2:0]      L_LAT  = 3'(ENG_LAT);

    logic [2:0]            r_state;
    logic [ID_W-1:0]       r_grant;
    logic [ID_W-1:0]       r_rr_ptr;
    logic [2:0]            r_cnt;
    logic                  r_eng_vld;
    logic [DATA_WIDTH-1:0] r_eng_din;
    logic                  r_res_vld;
    logic [ID_W-1:0]       r_res_id;
    logic [CRC_WIDTH-1:0]  r_res_crc;

    logic                  w_any_vld;
    logic                  w_found;
    logic [ID_W:0]         w_idx;
    logic [ID_W-1:0]       w_pick;
    logic                  w_sel_vld;
    logic                  w_sel_last;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_hs;
    logic [ID_W-1:0]       w_next_ptr;
    logic [NUM_REQ-1:0]    w_grant_onehot;

    // Rotating priority search: first valid requester at or after r_rr_ptr.
    always_comb begin
        w_any_vld = |req_vld;
        w_found   = 1'b0;
        w_idx     = '0;
        w_pick    = r_rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            if (w_idx >= L_NUM) begin
                w_idx = w_idx - L_NUM;
            end
            if (!w_found && req_vld[w_idx[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        w_sel_vld      = 1'b0;
        w_sel_last     = 1'b0;
        w_sel_data     = '0;
        w_grant_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant == ID_W'(i)) begin
                w_sel_vld         = req_vld[i];
                w_sel_last        = req_last[i];
                w_sel_data        = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                w_grant_onehot[i] = 1'b1;
            end
        end
    end

    assign w_hs       = (r_state == S_STREAM) && w_sel_vld;
    assign w_next_ptr = (r_grant == L_LAST) ? '0 : r_grant + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_vld) begin
                        r_grant <= w_pick;
                        r_state <= S_INIT;
                    end
                end
                S_INIT: begin
                    r_state <= S_STREAM;
                end
                S_STREAM: begin
                    if (w_hs && w_sel_last) begin
                        r_cnt   <= L_LAT;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 3'd0) begin
                        r_state <= S_RESULT;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_RESULT: begin
                    // Pointer moves only on accept, so a frame in flight never loses its turn.
                    if (res_rdy) begin
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_eng_vld <= 1'b0;
            r_eng_din <= '0;
        end else begin
            r_eng_vld <= w_hs;
            if (w_hs) begin
                r_eng_din <= w_sel_data;
            end
        end
    end

    // The counter hits zero on the edge where eng_crc carries the last beat's CRC.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_res_vld <= 1'b0;
            r_res_id  <= '0;
            r_res_crc <= '0;
        end else begin
            if (r_state == S_WAIT && r_cnt == 3'd0) begin
                r_res_vld <= 1'b1;
                r_res_id  <= r_grant;
                r_res_crc <= eng_crc;
            end else if (r_state == S_RESULT && res_rdy) begin
                r_res_vld <= 1'b0;
            end
        end
    end

    assign req_rdy  = (r_state == S_STREAM) ? w_grant_onehot : '0;
    assign eng_init = (r_state == S_INIT);
    assign eng_vld  = r_eng_vld;
    assign eng_din  = r_eng_din;
    assign res_vld  = r_res_vld;
    assign res_id   = r_res_id;
    assign res_crc  = r_res_crc;
    assign busy     = (r_state != S_IDLE);

endmodule
